product_accum: RTL and testbench

PRODUCT_ACCUM -- requirements
Module: product_accum

---
 rtl/product_accum.sv | 94 +++++++++
 tb/tb_product_accum.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_accum.sv
// Accumulates four shifted partial products into a 16-bit product for an 8x8 multiply.
// Optional sticky carry-out flag 'ovf' is enabled by defining PRODUCT_ACCUM_OVF_EN.
module product_accum (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] shift_in,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [1:0]  pp_count
`ifdef PRODUCT_ACCUM_OVF_EN
    ,
    output logic        ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] product_next;
    logic [1:0]  count_next;
    logic        accept;

    // start always wins, so a restart cycle never accepts the partial on shift_in
    assign accept = (state == ACCUM) && in_valid && !start;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state    <= IDLE;
            product  <= 16'h0000;
            pp_count <= 2'd0;
        end else begin
            state    <= state_next;
            product  <= product_next;
            pp_count <= count_next;
        end
    end

    always_comb begin
        state_next   = state;
        product_next = product;
        count_next   = pp_count;
        if (start) begin
            state_next   = ACCUM;
            product_next = 16'h0000;
            count_next   = 2'd0;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                ACCUM: begin
                    if (accept) begin
                        product_next = product + shift_in;
                        count_next   = pp_count + 2'd1;
                        if (pp_count == 2'd3) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign in_ready = (state == ACCUM);
    assign busy     = (state == ACCUM) || (state == DONE);
    assign done     = (state == DONE);

`ifdef PRODUCT_ACCUM_OVF_EN
    logic [16:0] sum_wide;

    assign sum_wide = {1'b0, product} + {1'b0, shift_in};

    // Sticky until the next start, so it survives DONE and IDLE for readback
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            ovf <= 1'b0;
        end else if (start) begin
            ovf <= 1'b0;
        end else if (accept && sum_wide[16]) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_product_accum.sv
// Self-checking bench for product_accum: directed scenarios plus randomized traffic
// checked against a list-of-accepted-partials reference model.
module tb_product_accum;

    logic        clk;
    logic        reset_a;
    logic        start;
    logic        in_valid;
    logic [15:0] shift_in;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [1:0]  pp_count;
`ifdef PRODUCT_ACCUM_OVF_EN
    logic        ovf;
`endif

    int compared;
    int mismatched;
    int done_pulses;

    // Reference model: partials accepted since the last start, plus run phase flags
    logic [15:0] parts[$];
    bit          collecting;
    bit          finished;

    product_accum dut (
        .clk      (clk),
        .reset_a  (reset_a),
        .start    (start),
        .in_valid (in_valid),
        .shift_in (shift_in),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .pp_count (pp_count)
`ifdef PRODUCT_ACCUM_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_product();
        int s = 0;
        foreach (parts[i]) s = s + int'(parts[i]);
        return 16'(s % 65536);
    endfunction

    function automatic logic model_ovf();
        int run = 0;
        logic f = 1'b0;
        foreach (parts[i]) begin
            run = run + int'(parts[i]);
            if (run > 65535) begin
                f   = 1'b1;
                run = run - 65536;
            end
        end
        return f;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_output({tag, ".in_ready"}, 32'(in_ready), 32'(collecting));
        check_output({tag, ".busy"}, 32'(busy), 32'(collecting || finished));
        check_output({tag, ".done"}, 32'(done), 32'(finished));
        check_output({tag, ".product"}, 32'(product), 32'(model_product()));
        check_output({tag, ".pp_count"}, 32'(pp_count), 32'(parts.size() % 4));
`ifdef PRODUCT_ACCUM_OVF_EN
        check_output({tag, ".ovf"}, 32'(ovf), 32'(model_ovf()));
`endif
    endtask

    task automatic model_reset();
        parts.delete();
        collecting = 1'b0;
        finished   = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic iv, input logic [15:0] d);
        finished = 1'b0;
        if (s) begin
            parts.delete();
            collecting = 1'b1;
        end else if (collecting && iv) begin
            parts.push_back(d);
            if (parts.size() == 4) begin
                collecting = 1'b0;
                finished   = 1'b1;
            end
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic s, input logic iv,
                                  input logic [15:0] d);
        start    = s;
        in_valid = iv;
        shift_in = d;
        @(posedge clk);
        model_edge(s, iv, d);
        #1;
        if (done) done_pulses++;
        check_all(tag);
    endtask

    // Called at posedge+1; asserts reset mid-cycle and releases it before the next edge
    task automatic pulse_reset(input string tag);
        #3;
        reset_a = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #2;
        reset_a = 1'b1;
    endtask

    initial begin
        logic [15:0] pp_ff[4];
        compared    = 0;
        mismatched  = 0;
        done_pulses = 0;
        reset_a     = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        shift_in    = 16'h0000;
        model_reset();
        #2;
        check_all("reset");
        #6;
        reset_a = 1'b1;

        // 0xFF x 0xFF
        pp_ff = '{16'h00E1, 16'h0E10, 16'h0E10, 16'hE100};
        apply_stimulus("ff_start", 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) apply_stimulus("ff_pp", 1'b0, 1'b1, pp_ff[i]);
        check_output("ff_done", 32'(done), 32'd1);
        check_output("ff_product", 32'(product), 32'hFE01);
        check_output("ff_count", 32'(pp_count), 32'd0);
        apply_stimulus("ff_idle", 1'b0, 1'b1, 16'h1234);
        check_output("ff_hold", 32'(product), 32'hFE01);
        apply_stimulus("ff_idle2", 1'b0, 1'b1, 16'h1234);

        // Gapped input stream, done must fire exactly once
        done_pulses = 0;
        apply_stimulus("gap_start", 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus("gap_pp", 1'b0, 1'b1, (i == 0) ? 16'h0006 : 16'h0000);
            if (i < 3) begin
                apply_stimulus("gap_idle", 1'b0, 1'b0, 16'hBEEF);
                apply_stimulus("gap_idle", 1'b0, 1'b0, 16'hBEEF);
            end
        end
        check_output("gap_product", 32'(product), 32'h0006);
        for (int i = 0; i < 3; i++) apply_stimulus("gap_after", 1'b0, 1'b0, 16'h0000);
        check_output("gap_done_once", 32'(done_pulses), 32'd1);

        // Restart mid-accumulation discards the coincident partial
        apply_stimulus("rs_start", 1'b1, 1'b0, 16'h0000);
        apply_stimulus("rs_pp", 1'b0, 1'b1, 16'h1000);
        apply_stimulus("rs_pp", 1'b0, 1'b1, 16'h0200);
        apply_stimulus("rs_restart", 1'b1, 1'b1, 16'h0FFF);
        check_output("rs_product", 32'(product), 32'h0000);
        check_output("rs_accum", 32'(in_ready), 32'd1);

        // Restart from DONE still shows the done pulse
        for (int i = 0; i < 4; i++) apply_stimulus("dn_pp", 1'b0, 1'b1, 16'h0101);
        apply_stimulus("dn_restart", 1'b1, 1'b1, 16'h1234);
        check_output("dn_restart_accum", 32'(in_ready), 32'd1);

        // Reset mid-accumulation, then in_valid ignored until start
        for (int i = 0; i < 3; i++) apply_stimulus("ra_pp", 1'b0, 1'b1, 16'h0111);
        pulse_reset("ra_reset");
        check_output("ra_product", 32'(product), 32'h0000);
        for (int i = 0; i < 3; i++) apply_stimulus("ra_ignored", 1'b0, 1'b1, 16'h0F0F);
        check_output("ra_still_idle", 32'(busy), 32'd0);

`ifdef PRODUCT_ACCUM_OVF_EN
        apply_stimulus("ov_start", 1'b1, 1'b0, 16'h0000);
        apply_stimulus("ov_pp", 1'b0, 1'b1, 16'hFFFF);
        apply_stimulus("ov_pp", 1'b0, 1'b1, 16'h0002);
        apply_stimulus("ov_pp", 1'b0, 1'b1, 16'h0000);
        apply_stimulus("ov_pp", 1'b0, 1'b1, 16'h0000);
        check_output("ov_product", 32'(product), 32'h0001);
        check_output("ov_flag_done", 32'(ovf), 32'd1);
        apply_stimulus("ov_idle", 1'b0, 1'b0, 16'h0000);
        check_output("ov_flag_idle", 32'(ovf), 32'd1);
        apply_stimulus("ov_clear", 1'b1, 1'b0, 16'h0000);
        check_output("ov_cleared", 32'(ovf), 32'd0);
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic        s;
            logic        iv;
            logic [15:0] d;
            s  = ($urandom_range(0, 11) == 0);
            iv = ($urandom_range(0, 2) != 0);
            d  = 16'($urandom);
            apply_stimulus("rand", s, iv, d);
            if ($urandom_range(0, 59) == 0) pulse_reset("rand_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
